sd_photo_seq_reader: RTL and testbench
======================================

Name: sd_photo_seq_reader

Overview:
- Parametrised successor to the single-photo SD sector sequencer.
- Issues consecutive SD sector-read requests to the SD controller's read port (rd_start_en / rd_sec_addr / rd_busy) for one of PHOTO_NUM stored photos.
- Runs in single-shot mode (one selected photo) or slideshow mode (loops through all photos with a dwell gap).
- Emits frame_start and frame_done pulses so the top level can reload the SDRAM write address per photo.

Parameters:
- PHOTO_H, 800, photo width in pixels.
- PHOTO_V, 480, photo height in pixels.
- BPP_BYTES, 2, bytes per pixel (RGB565 = 2).
- PHOTO_NUM, 4, number of photos stored on card (1..16).
- BASE_SEC, 32'd16640, first sector of photo 0.
- STRIDE_SEC, 32'd2048, sector distance between consecutive photo starts.
- DWELL_CYC, 50_000_000, idle cycles between photos in slideshow (>=1).
- TIMEOUT_CYC, 1_000_000, rd_busy-rise watchdog limit (optional feature only).

Ports:
- clk  in  1  controller clock (SD controller reference clock).
- rst  in  1  asynchronous reset, active-high.
- start  in  1  begin-sequence pulse; ignored while busy=1.
- mode  in  1  0 = single photo, 1 = slideshow loop.
- photo_sel  in  IDX_W  photo index for single mode; IDX_W = clog2(PHOTO_NUM), minimum 1.
- rd_busy  in  1  SD controller read busy.
- rd_start_en  out  1  one-cycle sector-read request.
- rd_sec_addr  out  32  sector address; stable whenever rd_start_en is high.
- frame_start  out  1  one-cycle pulse before a photo's first sector.
- frame_done  out  1  one-cycle pulse after a photo's last sector completes.
- cur_photo  out  IDX_W  index of the photo being read.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Sector count: localparam SEC_PER_PHOTO = ceil(PHOTO_H*PHOTO_V*BPP_BYTES/512), computed in 32-bit arithmetic. Sector counter width = clog2(SEC_PER_PHOTO)+1.
- Reset values: all outputs 0; state IDLE; counters 0.
- FSM states: IDLE, LOAD, ISSUE, WAIT_H, WAIT_L, NEXT, DWELL.
- IDLE: on start=1, latch mode into mode_r and go to LOAD.
  - Single mode: cur_photo <= min(photo_sel, PHOTO_NUM-1).
  - Slideshow mode: cur_photo <= 0.
- LOAD (1 cycle):
  - frame_start=1, sec_cnt<=0.
  - rd_sec_addr <= BASE_SEC + cur_photo*STRIDE_SEC, modulo 2^32.
- ISSUE (1 cycle): rd_start_en=1, then go to WAIT_H. start -> rd_start_en latency is exactly 2 cycles.
- WAIT_H: wait for rd_busy=1, then go to WAIT_L. If rd_busy is already 1 on entry, advance on the next cycle.
- WAIT_L: on rd_busy=0 go to NEXT.
- NEXT:
  - Not last sector (sec_cnt != SEC_PER_PHOTO-1): sec_cnt+1, rd_sec_addr+1, go to ISSUE.
  - Last sector: frame_done=1.
    - mode_r=0 or mode=0 -> IDLE. Deasserting mode mid-slideshow stops after the current photo completes.
    - Otherwise -> DWELL.
- DWELL: count DWELL_CYC cycles, then cur_photo <= (cur_photo==PHOTO_NUM-1) ? 0 : cur_photo+1 and go to LOAD.
- start while busy is ignored; photo_sel and mode changes do not affect the photo being read.
- Asserting rst mid-operation returns to IDLE immediately and drops rd_start_en the same edge. No outstanding request is tracked.
- PHOTO_NUM=1: slideshow re-reads photo 0 every loop.

Optional Feature:
- Macro: SD_PHOTO_TIMEOUT_EN.
- Defined:
  - WAIT_H counts cycles; if rd_busy does not rise within TIMEOUT_CYC, the FSM returns to ISSUE and re-requests the same address.
  - Adds output to_cnt [7:0], saturating count of retries, reset 0.
- Undefined: WAIT_H waits indefinitely and to_cnt is absent.

Decomposition:
- Package sd_photo_pkg: state enum, SEC_BYTES=512 constant, clog2-style sizing function for SEC_PER_PHOTO and IDX_W.
- One sub-module, sd_photo_dwell_timer: loadable down-counter with a done flag, reused for DWELL and the timeout watchdog.
- FSM and address arithmetic stay in the top module.

Test Plan:
Bench parameters: PHOTO_H=32, PHOTO_V=16, BPP_BYTES=2 (SEC_PER_PHOTO=2), PHOTO_NUM=3, BASE_SEC=1000, STRIDE_SEC=8, DWELL_CYC=10. SD model raises rd_busy 2 cycles after the request and holds it 5 cycles.
- Single mode, photo_sel=1, start -> rd_start_en pulses at addresses 1008 and 1009; one frame_start before, one frame_done after; busy returns to 0.
- photo_sel=3 (out of range) -> clamped, addresses 1016 and 1017; cur_photo=2.
- Slideshow -> address order 1000, 1001, 1008, 1009, 1016, 1017, 1000…; at least 10 idle cycles between frame_done and the next frame_start.
- mode drops during photo 1 of slideshow -> 1009 completes, frame_done fires, FSM goes to IDLE, no further requests.
- rst asserted while in WAIT_L -> all outputs 0 asynchronously; new start replays from LOAD.
- SD_PHOTO_TIMEOUT_EN with TIMEOUT_CYC=20 and model never raising rd_busy -> rd_start_en re-pulses at the same address every ~22 cycles; to_cnt increments.

Source files
------------

// File: rtl/sd_photo_pkg.sv
// Shared state encoding and compile-time sizing helpers for the SD photo sequence reader.
package sd_photo_pkg;

    localparam int unsigned SEC_BYTES = 512;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT_H = 3'd3,
        S_WAIT_L = 3'd4,
        S_NEXT   = 3'd5,
        S_DWELL  = 3'd6
    } state_t;

    function automatic int unsigned f_clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << r) < 64'(n)) r = r + 1;
        end
        return r;
    endfunction

    // Index width never collapses to zero, even for a single stored photo.
    function automatic int unsigned f_idx_w(input int unsigned n);
        return (n <= 2) ? 1 : f_clog2(n);
    endfunction

    function automatic int unsigned f_sec_per_photo(input int unsigned h, input int unsigned v,
                                                    input int unsigned b);
        logic [31:0] bytes;
        bytes = 32'(h * v * b);
        return (bytes + SEC_BYTES - 1) / SEC_BYTES;
    endfunction

endpackage

// File: rtl/sd_photo_dwell_timer.sv
// Loadable down-counter; done is high whenever the count has reached zero.
module sd_photo_dwell_timer #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (cnt_q != '0)
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/sd_photo_seq_reader.sv
// Sequences SD sector reads for one photo or a looping slideshow of PHOTO_NUM photos.
// Optional rd_busy watchdog with retry counter: define SD_PHOTO_TIMEOUT_EN.
//   state    | meaning
//   IDLE     | waiting for start
//   LOAD     | frame_start, compute first sector of cur_photo
//   ISSUE    | one-cycle rd_start_en
//   WAIT_H   | waiting for controller to raise rd_busy
//   WAIT_L   | waiting for the sector read to finish
//   NEXT     | advance sector or finish photo (frame_done)
//   DWELL    | slideshow gap before the next photo
module sd_photo_seq_reader
    import sd_photo_pkg::*;
#(
    parameter int unsigned PHOTO_H     = 800,
    parameter int unsigned PHOTO_V     = 480,
    parameter int unsigned BPP_BYTES   = 2,
    parameter int unsigned PHOTO_NUM   = 4,
    parameter logic [31:0] BASE_SEC    = 32'd16640,
    parameter logic [31:0] STRIDE_SEC  = 32'd2048,
    parameter int unsigned DWELL_CYC   = 50_000_000,
    parameter int unsigned TIMEOUT_CYC = 1_000_000,
    localparam int unsigned IDX_W      = f_idx_w(PHOTO_NUM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [IDX_W-1:0] photo_sel,
    input  logic             rd_busy,
    output logic             rd_start_en,
    output logic [31:0]      rd_sec_addr,
    output logic             frame_start,
    output logic             frame_done,
    output logic [IDX_W-1:0] cur_photo,
    output logic             busy
`ifdef SD_PHOTO_TIMEOUT_EN
    ,
    output logic [7:0]       to_cnt
`endif
);

    localparam int unsigned SEC_PER_PHOTO = f_sec_per_photo(PHOTO_H, PHOTO_V, BPP_BYTES);
    localparam int unsigned SC_W          = f_clog2(SEC_PER_PHOTO) + 1;
    // One timer serves both the dwell gap and the watchdog, so size it for the longer one.
    localparam int unsigned TMR_MAX       = (DWELL_CYC > TIMEOUT_CYC) ? DWELL_CYC : TIMEOUT_CYC;
    localparam int unsigned TMR_W         = f_clog2(TMR_MAX) + 1;
    localparam logic [SC_W-1:0]  SEC_LAST   = SC_W'(SEC_PER_PHOTO - 1);
    localparam logic [TMR_W-1:0] DWELL_LOAD = TMR_W'(DWELL_CYC - 1);

    state_t           state_q, state_d;
    logic             mode_r_q, mode_r_d;
    logic [IDX_W-1:0] cur_photo_q, cur_photo_d;
    logic [SC_W-1:0]  sec_cnt_q, sec_cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic [IDX_W-1:0] sel_clamped;
    logic [IDX_W-1:0] photo_next;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_done;
`ifdef SD_PHOTO_TIMEOUT_EN
    localparam logic [TMR_W-1:0] TO_LOAD = TMR_W'(TIMEOUT_CYC - 1);
    logic [7:0]       to_cnt_q, to_cnt_d;
`endif

    assign sel_clamped = (32'(photo_sel) > PHOTO_NUM - 1) ? IDX_W'(PHOTO_NUM - 1) : photo_sel;
    assign photo_next  = (32'(cur_photo_q) == PHOTO_NUM - 1) ? '0 : cur_photo_q + IDX_W'(1);

    sd_photo_dwell_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_comb begin
        state_d     = state_q;
        mode_r_d    = mode_r_q;
        cur_photo_d = cur_photo_q;
        sec_cnt_d   = sec_cnt_q;
        addr_d      = addr_q;
        tmr_load    = 1'b0;
        tmr_val     = DWELL_LOAD;
        rd_start_en = 1'b0;
        frame_start = 1'b0;
        frame_done  = 1'b0;
`ifdef SD_PHOTO_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_r_d    = mode;
                    cur_photo_d = mode ? '0 : sel_clamped;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                frame_start = 1'b1;
                sec_cnt_d   = '0;
                addr_d      = BASE_SEC + 32'(cur_photo_q) * STRIDE_SEC;
                state_d     = S_ISSUE;
            end
            S_ISSUE: begin
                rd_start_en = 1'b1;
                state_d     = S_WAIT_H;
`ifdef SD_PHOTO_TIMEOUT_EN
                tmr_load    = 1'b1;
                tmr_val     = TO_LOAD;
`endif
            end
            S_WAIT_H: begin
                if (rd_busy) begin
                    state_d = S_WAIT_L;
                end
`ifdef SD_PHOTO_TIMEOUT_EN
                else if (tmr_done) begin
                    state_d = S_ISSUE;
                    if (to_cnt_q != 8'hFF) to_cnt_d = to_cnt_q + 8'd1;
                end
`endif
            end
            S_WAIT_L: begin
                if (!rd_busy) state_d = S_NEXT;
            end
            S_NEXT: begin
                if (sec_cnt_q != SEC_LAST) begin
                    sec_cnt_d = sec_cnt_q + SC_W'(1);
                    addr_d    = addr_q + 32'd1;
                    state_d   = S_ISSUE;
                end else begin
                    frame_done = 1'b1;
                    // Dropping mode mid-slideshow ends the loop once this photo is complete.
                    if (!mode_r_q || !mode) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d  = S_DWELL;
                        tmr_load = 1'b1;
                    end
                end
            end
            S_DWELL: begin
                if (tmr_done) begin
                    cur_photo_d = photo_next;
                    state_d     = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mode_r_q    <= 1'b0;
            cur_photo_q <= '0;
            sec_cnt_q   <= '0;
            addr_q      <= '0;
        end else begin
            state_q     <= state_d;
            mode_r_q    <= mode_r_d;
            cur_photo_q <= cur_photo_d;
            sec_cnt_q   <= sec_cnt_d;
            addr_q      <= addr_d;
        end
    end

`ifdef SD_PHOTO_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) to_cnt_q <= '0;
        else     to_cnt_q <= to_cnt_d;
    end
    assign to_cnt = to_cnt_q;
`endif

    assign rd_sec_addr = addr_q;
    assign cur_photo   = cur_photo_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_sd_photo_seq_reader.sv
// Self-checking bench for sd_photo_seq_reader with a small SD read-port model.
module tb_sd_photo_seq_reader;

    localparam int PN     = 3;
    localparam int SEC    = 2;
    localparam int BASE   = 1000;
    localparam int STRIDE = 8;
    localparam int DWELL  = 10;

    logic        clk = 1'b0;
    logic        rst, start, mode, rd_busy;
    logic [1:0]  photo_sel;
    logic        rd_start_en, frame_start, frame_done, busy;
    logic [31:0] rd_sec_addr;
    logic [1:0]  cur_photo;
`ifdef SD_PHOTO_TIMEOUT_EN
    logic [7:0]  to_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    sd_photo_seq_reader #(
        .PHOTO_H(32), .PHOTO_V(16), .BPP_BYTES(2), .PHOTO_NUM(PN),
        .BASE_SEC(32'd1000), .STRIDE_SEC(32'd8), .DWELL_CYC(DWELL), .TIMEOUT_CYC(20)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .photo_sel(photo_sel),
        .rd_busy(rd_busy), .rd_start_en(rd_start_en), .rd_sec_addr(rd_sec_addr),
        .frame_start(frame_start), .frame_done(frame_done), .cur_photo(cur_photo),
        .busy(busy)
`ifdef SD_PHOTO_TIMEOUT_EN
        , .to_cnt(to_cnt)
`endif
    );

    // SD controller model: busy rises 2 cycles after a request and stays high 5 cycles.
    bit sd_silent = 1'b0;
    bit sd_clear  = 1'b0;
    int sd_pend   = 0;
    int sd_hold   = 0;
    initial begin
        rd_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (sd_clear) begin
                sd_pend = 0; sd_hold = 0; rd_busy = 1'b0;
            end else if (sd_pend > 0) begin
                sd_pend--;
                if (sd_pend == 0) begin rd_busy = 1'b1; sd_hold = 5; end
            end else if (sd_hold > 0) begin
                sd_hold--;
                if (sd_hold == 0) rd_busy = 1'b0;
            end else if (rd_start_en && !sd_silent) begin
                sd_pend = 2;
            end
        end
    end

    int req_q[$], req_cyc[$], fs_cyc[$], fd_cyc[$];
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (rd_start_en) begin req_q.push_back(int'(rd_sec_addr)); req_cyc.push_back(cyc); end
            if (frame_start) fs_cyc.push_back(cyc);
            if (frame_done)  fd_cyc.push_back(cyc);
        end
    end

    function automatic int exp_addr(input int photo, input int k);
        return BASE + photo * STRIDE + k;
    endfunction

    function automatic int clamp_sel(input int p);
        return (p > PN - 1) ? PN - 1 : p;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        req_q.delete(); req_cyc.delete(); fs_cyc.delete(); fd_cyc.delete();
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({rd_start_en, frame_start, frame_done, busy} !== 4'b0) begin
            errors++;
            $display("FAIL %s_flags: got %b want 0000", tag, {rd_start_en, frame_start, frame_done, busy});
        end
        checks++;
        if (rd_sec_addr !== 32'd0) begin
            errors++; $display("FAIL %s_addr: got %0d want 0", tag, rd_sec_addr);
        end
        checks++;
        if (cur_photo !== 2'd0) begin
            errors++; $display("FAIL %s_cur_photo: got %0d want 0", tag, cur_photo);
        end
    endtask

    task automatic wait_idle(input int budget, input bit jitter);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (!busy) begin ok = 1'b1; break; end
            if (jitter) begin
                start     = 1'($urandom_range(0, 1));
                photo_sel = 2'($urandom_range(0, 3));
                mode      = 1'($urandom_range(0, 1));
            end
        end
        start = 1'b0;
        mode  = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL idle_wait: busy still %b after %0d cycles, want 0", busy, budget); end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mode = 1'b0; photo_sel = 2'd0;
        repeat (3) tick();
        check_all_zero("reset_held");
        rst = 1'b0;
        tick();
        check_all_zero("reset_released");
    endtask

    task automatic test_single(input int psel);
        int p;
        p = clamp_sel(psel);
        clear_log();
        mode = 1'b0; photo_sel = 2'(psel); start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (frame_start !== 1'b1 || rd_start_en !== 1'b0) begin
            errors++; $display("FAIL single_load_cycle: frame_start=%b rd_start_en=%b want 1 0", frame_start, rd_start_en);
        end
        tick();
        checks++;
        if (rd_start_en !== 1'b1 || rd_sec_addr !== 32'(exp_addr(p, 0))) begin
            errors++; $display("FAIL single_latency: rd_start_en=%b addr=%0d want 1 %0d", rd_start_en, rd_sec_addr, exp_addr(p, 0));
        end
        wait_idle(300, 1'b1);
        checks++;
        if (req_q.size() != SEC) begin
            errors++; $display("FAIL single_req_count: got %0d want %0d", req_q.size(), SEC);
        end
        for (int k = 0; k < req_q.size() && k < SEC; k++) begin
            checks++;
            if (req_q[k] != exp_addr(p, k)) begin
                errors++; $display("FAIL single_addr[%0d]: got %0d want %0d", k, req_q[k], exp_addr(p, k));
            end
        end
        checks++;
        if (fs_cyc.size() != 1 || fd_cyc.size() != 1) begin
            errors++; $display("FAIL single_frame_pulses: starts=%0d dones=%0d want 1 1", fs_cyc.size(), fd_cyc.size());
        end else if (req_q.size() == SEC) begin
            checks++;
            if (!(fs_cyc[0] < req_cyc[0] && fd_cyc[0] > req_cyc[SEC-1])) begin
                errors++; $display("FAIL single_frame_order: fs=%0d first_req=%0d fd=%0d last_req=%0d", fs_cyc[0], req_cyc[0], fd_cyc[0], req_cyc[SEC-1]);
            end
        end
        checks++;
        if (cur_photo !== 2'(p)) begin
            errors++; $display("FAIL single_cur_photo: got %0d want %0d", cur_photo, p);
        end
    endtask

    task automatic run_slideshow(input string tag, input int n_drop);
        int total;
        bit ok;
        total = ((n_drop + SEC - 1) / SEC) * SEC;
        clear_log();
        mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (!busy) begin ok = 1'b1; break; end
            if (mode && req_q.size() >= n_drop) mode = 1'b0;
            start     = 1'($urandom_range(0, 1));
            photo_sel = 2'($urandom_range(0, 3));
        end
        start = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL %s_idle_wait: busy=%b want 0", tag, busy); end
        repeat (30) tick();
        checks++;
        if (req_q.size() != total) begin
            errors++; $display("FAIL %s_req_count: got %0d want %0d", tag, req_q.size(), total);
        end
        for (int i = 0; i < req_q.size() && i < total; i++) begin
            checks++;
            if (req_q[i] != exp_addr((i / SEC) % PN, i % SEC)) begin
                errors++; $display("FAIL %s_addr[%0d]: got %0d want %0d", tag, i, req_q[i], exp_addr((i / SEC) % PN, i % SEC));
            end
        end
        checks++;
        if (fs_cyc.size() != total / SEC || fd_cyc.size() != total / SEC) begin
            errors++; $display("FAIL %s_frame_pulses: starts=%0d dones=%0d want %0d", tag, fs_cyc.size(), fd_cyc.size(), total / SEC);
        end
        for (int i = 0; i + 1 < fs_cyc.size() && i < fd_cyc.size(); i++) begin
            checks++;
            if (fs_cyc[i+1] - fd_cyc[i] - 1 < DWELL || fs_cyc[i+1] - fd_cyc[i] - 1 > DWELL + 1) begin
                errors++; $display("FAIL %s_dwell[%0d]: got %0d idle cycles want %0d", tag, i, fs_cyc[i+1] - fd_cyc[i] - 1, DWELL);
            end
        end
    endtask

    task automatic test_slideshow();
        run_slideshow("slide_wrap", 7);
        run_slideshow("slide_rand", $urandom_range(5, 10));
    endtask

    task automatic test_mode_drop();
        run_slideshow("mode_drop", 3);
    endtask

    task automatic test_reset_mid();
        int psel;
        bit ok;
        psel = $urandom_range(0, 2);
        clear_log();
        mode = 1'b0; photo_sel = 2'(psel); start = 1'b1;
        tick();
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (rd_busy) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL mid_rst_busy_wait: rd_busy=%b want 1", rd_busy); end
        tick();
        #2 rst = 1'b1;
        #1;
        check_all_zero("mid_rst");
        tick();
        sd_clear = 1'b1;
        tick(); tick();
        sd_clear = 1'b0;
        rst = 1'b0;
        tick();
        test_single(psel);
    endtask

`ifdef SD_PHOTO_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        clear_log();
        sd_silent = 1'b1;
        mode = 1'b0; photo_sel = 2'd0; start = 1'b1;
        tick();
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (req_q.size() >= 4) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL timeout_retries: got %0d requests want 4", req_q.size()); end
        for (int i = 0; i < req_q.size(); i++) begin
            checks++;
            if (req_q[i] != BASE) begin errors++; $display("FAIL timeout_addr[%0d]: got %0d want %0d", i, req_q[i], BASE); end
        end
        for (int i = 0; i + 1 < req_cyc.size(); i++) begin
            checks++;
            if (req_cyc[i+1] - req_cyc[i] < 20 || req_cyc[i+1] - req_cyc[i] > 24) begin
                errors++; $display("FAIL timeout_period[%0d]: got %0d cycles want 20..24", i, req_cyc[i+1] - req_cyc[i]);
            end
        end
        checks++;
        if (to_cnt !== 8'd3) begin errors++; $display("FAIL timeout_to_cnt: got %0d want 3", to_cnt); end
        rst = 1'b1;
        tick();
        sd_silent = 1'b0;
        checks++;
        if (to_cnt !== 8'd0) begin errors++; $display("FAIL timeout_to_cnt_reset: got %0d want 0", to_cnt); end
        rst = 1'b0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single(1);
        test_single(3);
        for (int i = 0; i < 4; i++) test_single($urandom_range(0, 3));
        test_slideshow();
        test_mode_drop();
        test_reset_mid();
`ifdef SD_PHOTO_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
